// File: rtl/hs_stream_upsizer.sv
// Narrow-to-wide stream upsizer: packs RATIO input beats into one output word.
// Frames that end early on last are flushed as a partial word with a lane strobe.
module hs_stream_upsizer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RATIO  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic                    in_last_i,
  input  logic                    in_vld_i,
  output logic                    in_rdy_o,
  output logic [DATA_W*RATIO-1:0] out_data_o,
  output logic [RATIO-1:0]        out_strb_o,
  output logic                    out_last_o,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i
);

  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("hs_stream_upsizer: RATIO must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [RATIO-2:0][DATA_W-1:0]      acc_q, acc_d;
  logic [RATIO-1:0][DATA_W-1:0]      out_data_q, out_data_d;
  logic [RATIO-1:0]                  out_strb_q, out_strb_d;
  logic                              out_last_q, out_last_d;
  logic                              out_vld_q, out_vld_d;

  logic in_rdy, in_fire, out_fire, at_last_lane, completing;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_strb_d = out_strb_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    // Ready depends only on registered state and downstream ready, never on in_vld_i.
    in_rdy       = rst_ni && (!out_vld_q || out_rdy_i);
    in_fire      = in_vld_i && in_rdy;
    out_fire     = out_vld_q && out_rdy_i;
    at_last_lane = (cnt_q == CNT_W'(RATIO - 1));
    completing   = at_last_lane || in_last_i;

    if (out_fire) begin
      out_vld_d = 1'b0;
    end

    if (in_fire) begin
      if (!completing) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (cnt_q == CNT_W'(k)) acc_d[k] = in_data_i;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        // Lanes below cnt come from the accumulator, lane cnt is the current beat, the rest are zero.
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (CNT_W'(k) < cnt_q)       out_data_d[k] = acc_q[k];
          else if (CNT_W'(k) == cnt_q) out_data_d[k] = in_data_i;
          else                         out_data_d[k] = '0;
          out_strb_d[k] = (CNT_W'(k) <= cnt_q);
        end
        out_data_d[RATIO-1] = at_last_lane ? in_data_i : '0;
        out_strb_d[RATIO-1] = at_last_lane;
        out_last_d          = in_last_i;
        out_vld_d           = 1'b1;
        cnt_d               = '0;
        acc_d               = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_strb_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_strb_q <= out_strb_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign in_rdy_o   = in_rdy;
  assign out_data_o = out_data_q;
  assign out_strb_o = out_strb_q;
  assign out_last_o = out_last_q;
  assign out_vld_o  = out_vld_q;

endmodule

// File: doc/hs_stream_upsizer.md
Name: hs_stream_upsizer

Overview:
- Receive-side endpoint of the team's vld/rdy/last handshake stream. It acts as the "in" end of a narrow DATA_W stream and drives rdy.
- Packs RATIO consecutive narrow beats into one wide word and emits it on the "out" end of a DATA_W*RATIO handshake stream.
- Frames ended early by last are flushed as a partial word with a lane strobe.
- Sits between narrow producers (byte/stream sources) and wide datapath consumers.

Parameters:
- DATA_W, 8, width of one input beat in bits.
- RATIO, 4, input beats per output word. Legal range is 2 or more; elaboration fails for RATIO < 2.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- in_data_i  in  DATA_W  input beat data.
- in_last_i  in  1  input beat is the last of its frame.
- in_vld_i  in  1  input beat valid.
- in_rdy_o  out  1  upsizer accepts the input beat.
- out_data_o  out  DATA_W*RATIO  packed word; lane k = bits [k*DATA_W +: DATA_W].
- out_strb_o  out  RATIO  lane k holds a received beat.
- out_last_o  out  1  word ends a frame.
- out_vld_o  out  1  output word valid.
- out_rdy_i  in  1  downstream accepts the word.

Behaviour:
- Handshake:
  - A transfer occurs on a rising edge where vld and rdy are both 1.
  - vld never depends combinationally on rdy.
  - Once out_vld_o=1, out_data_o, out_strb_o and out_last_o hold stable until the transfer completes.
- in_rdy_o = rst_ni && (!out_vld_o || out_rdy_i). It is purely a function of registered state and out_rdy_i; it has no path from in_vld_i or in_last_i.
- State:
  - Accumulator for lanes 0..RATIO-2.
  - Lane counter cnt, width $clog2(RATIO), range 0..RATIO-1.
  - Output register (data/strb/last/vld).
- On an accepted input beat:
  - Not completing (cnt < RATIO-1 and in_last_i=0): write beat into accumulator lane cnt; cnt <= cnt+1.
  - Completing (cnt == RATIO-1 or in_last_i=1):
    - Load output register: lanes 0..cnt-1 from accumulator, lane cnt = in_data_i, lanes above cnt = 0.
    - out_strb_o = bits 0..cnt set; out_last_o = in_last_i; out_vld_o <= 1.
    - cnt <= 0; accumulator cleared.
- On an output transfer with no simultaneous completing beat: out_vld_o <= 0. The other output registers keep their values.
- On an output transfer in the same cycle as a completing input beat: the new word loads and out_vld_o stays 1, so there is no bubble.
- Latency: out_vld_o rises on the cycle after the completing beat is accepted.
- Throughput: 1 input beat per cycle sustained with out_rdy_i=1; one word every RATIO beats.
- Backpressure: while out_vld_o=1 and out_rdy_i=0, in_rdy_o=0 and no beats are accepted, including non-completing ones. Accumulator and cnt hold.
- last on a full word (cnt==RATIO-1): full strobe and out_last_o=1. No extra empty word is generated.
- Consecutive frames: the next frame always starts in lane 0.
- Reset (rst_ni=0 at an edge), including mid-frame or while a word is held:
  - out_vld_o=0, out_last_o=0, out_strb_o=0, out_data_o=0.
  - cnt=0, accumulator=0.
  - in_rdy_o=0 while rst_ni=0.
  - A partial frame in progress is discarded.
- No X propagation: out_data_o lanes beyond the strobe are driven to 0.

Test Plan (DATA_W=8, RATIO=4):
- 8 beats 0x11..0x88, last on 0x88, out_rdy_i=1:
  - Words 0x44332211 strb 0xF last 0, then 0x88776655 strb 0xF last 1.
  - Each out_vld_o is asserted 1 cycle after the 4th/8th beat.
- Frame AA,BB,CC with last on CC, followed by frame 01..04: 0x00CCBBAA strb 0x7 last 1, then 0x04030201 strb 0xF last 1.
- Single-beat frame 0x5A with last: 0x0000005A strb 0x1 last 1.
- Word held with out_rdy_i=0 for 5 cycles while in_vld_i=1:
  - in_rdy_o=0 throughout and the output stays stable.
  - After out_rdy_i rises, all subsequent beats are accepted in order with no loss or duplication.
- Continuous 16-beat stream with out_rdy_i=1 and in_vld_i=1:
  - in_rdy_o stays 1 every cycle.
  - out_vld_o pulses every 4th cycle.
  - Words 0x03020100, 0x07060504, ...
- Reset asserted after 2 beats (0xA1, 0xA2) and again while a word is held:
  - All outputs are 0 and in_rdy_o=0 during reset.
  - Next beats 0xB1..0xB4 produce 0xB4B3B2B1 strb 0xF.
